wr_full_gen: RTL and testbench

Write-side flag and pointer-crossing stage of the async FIFO. Sits between the write controller and the read domain. Converts the write controller's extended write count into a registered Gray pointer for the read domain, and synchronizes the read domain's Gray pointer into the write clock. It generates the registered `full_o` that gates the write controller, plus almost-full, fill level and a sticky overflow flag.

---
 rtl/async_fifo_pkg.sv | 25 ++
 rtl/sync_chain.sv | 29 ++
 rtl/wr_full_gen.sv | 79 +++++++
 tb/tb_wr_full_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Pointer helpers shared by the write-side full and read-side empty generators.
package async_fifo_pkg;

  typedef logic [31:0] ptr_word_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return depth + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Callers zero-extend narrower pointers; leading zeros leave the prefix XOR unaffected.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[31] = gray[31];
    for (int unsigned i = 0; i < 31; i++) begin
      bin[30-i] = bin[31-i] ^ gray[30-i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer; no logic between stages.
module sync_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wr_full_gen.sv
// Write-side pointer crossing and full/almost-full/level/overflow flag generation.
module wr_full_gen
  import async_fifo_pkg::*;
#(
  parameter int DLY         = 1,
  parameter int FIFO_DEPTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LEVEL = (1 << FIFO_DEPTH) - 1
) (
  input  logic                  wr_clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [FIFO_DEPTH:0]   wr_cnt_i,
  input  logic [FIFO_DEPTH:0]   rd_gray_i,
  input  logic                  ovf_clr_i,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [FIFO_DEPTH:0]   wr_gray_o,
  output logic [FIFO_DEPTH:0]   wr_level_o,
  output logic                  ovf_o
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_LEVEL);

  // Register timing is modelled at zero delay; DLY is kept for drop-in compatibility only.
  if (SYNC_STAGES < 2 || DLY < 0) begin : g_param_err
    $error("wr_full_gen: SYNC_STAGES must be >= 2 and DLY non-negative");
  end

  logic          wr_inc;
  logic [PW-1:0] wr_bin_nxt;
  logic [PW-1:0] wr_gray_nxt;
  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] level_nxt;
  logic          full_nxt;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk_i   (wr_clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rd_gray_i),
    .q_o     (rq_gray)
  );

  always_comb begin
    wr_inc      = wr_en_i & ~full_o;
    wr_bin_nxt  = wr_cnt_i + {{(PW-1){1'b0}}, wr_inc};
    wr_gray_nxt = PW'(bin2gray(32'(wr_bin_nxt)));
    rq_bin      = PW'(gray2bin(32'(rq_gray)));
    level_nxt   = wr_bin_nxt - rq_bin;
    // Full: write pointer has lapped the read pointer, i.e. top two Gray bits inverted.
    full_nxt    = (wr_gray_nxt == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
  end

  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_o     <= 1'b0;
      afull_o    <= 1'b0;
      wr_gray_o  <= '0;
      wr_level_o <= '0;
      ovf_o      <= 1'b0;
    end else begin
      full_o     <= full_nxt;
      afull_o    <= (level_nxt >= AFULL_L);
      wr_gray_o  <= wr_gray_nxt;
      wr_level_o <= level_nxt;
      if (wr_en_i & full_o) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wr_full_gen.sv
// Directed bench for wr_full_gen with a simple write-controller counter model.
module tb_wr_full_gen;

  logic       wr_clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_cnt;
  logic [3:0] rd_gray;
  logic       ovf_clr;
  logic       full, afull, ovf;
  logic [3:0] wr_gray, wr_level;

  int n_checks = 0;
  int n_fail   = 0;

  wr_full_gen #(
    .DLY         (1),
    .FIFO_DEPTH  (3),
    .SYNC_STAGES (2),
    .AFULL_LEVEL (7)
  ) u_dut (
    .wr_clk_i   (wr_clk),
    .rst_n_i    (rst_n),
    .wr_en_i    (wr_en),
    .wr_cnt_i   (wr_cnt),
    .rd_gray_i  (rd_gray),
    .ovf_clr_i  (ovf_clr),
    .full_o     (full),
    .afull_o    (afull),
    .wr_gray_o  (wr_gray),
    .wr_level_o (wr_level),
    .ovf_o      (ovf)
  );

  always #5 wr_clk = ~wr_clk;

  // Write controller: advances its count on each accepted write.
  always @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) wr_cnt <= '0;
    else if (wr_en && !full) wr_cnt <= wr_cnt + 4'd1;
  end

  function automatic logic [3:0] tb_gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_gray;
    int         exp_lvl;

    rst_n = 1'b0; wr_en = 1'b0; rd_gray = '0; ovf_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_full",  32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_gray",  32'(wr_gray), 0);
    chk("rst_level", 32'(wr_level), 0);
    chk("rst_ovf",   32'(ovf), 0);

    // Fill from empty: Gray of 1..8 is 1,3,2,6,7,5,4,C.
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("fill_level", 32'(wr_level), 32'(i));
      chk("fill_gray",  32'(wr_gray), 32'(tb_gray(i)));
      chk("fill_afull", 32'(afull), (i >= 7) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(full), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("fill_gray_c", 32'(wr_gray), 32'hC);

    // Write while full sets overflow and holds pointer.
    tick();
    chk("ovf_set",   32'(ovf), 1);
    chk("ovf_gray",  32'(wr_gray), 32'hC);
    chk("ovf_level", 32'(wr_level), 8);
    chk("ovf_full",  32'(full), 1);
    wr_en = 1'b0; ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(ovf), 0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("ovf_set_beats_clr", 32'(ovf), 1);
    chk("ovf_gray_held",     32'(wr_gray), 32'hC);
    wr_en = 1'b0; ovf_clr = 1'b0;

    // Full release: read pointer 1 lands two edges after sampling.
    rd_gray = 4'b0001;
    tick();
    chk("rel_full_e1", 32'(full), 1);
    tick();
    chk("rel_full_e2", 32'(full), 1);
    chk("rel_lvl_e2",  32'(wr_level), 8);
    tick();
    chk("rel_full_e3", 32'(full), 0);
    chk("rel_lvl_e3",  32'(wr_level), 7);
    chk("rel_afull",   32'(afull), 1);

    // Synchronized read step and write on the same edge.
    rd_gray = 4'b0011;
    tick();
    chk("sim_lvl_a", 32'(wr_level), 7);
    tick();
    chk("sim_lvl_b", 32'(wr_level), 7);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("sim_level", 32'(wr_level), 7);
    chk("sim_full",  32'(full), 0);
    chk("sim_gray",  32'(wr_gray), 32'hD);

    // Drain: read pointer walks 3..9 one Gray step at a time.
    for (int v = 3; v <= 9; v++) begin
      rd_gray = tb_gray(v);
      tick();
    end
    tick(); tick(); tick();
    chk("drain_level", 32'(wr_level), 0);
    chk("drain_afull", 32'(afull), 0);
    chk("drain_full",  32'(full), 0);

    // Wrap-around: 40 writes, read side tracking; level settles at 3.
    exp_gray = 4'hD;
    wr_en = 1'b1;
    for (int m = 0; m < 40; m++) begin
      rd_gray = tb_gray(int'(wr_cnt));
      tick();
      exp_lvl = (m < 2) ? m + 1 : 3;
      chk("wrap_onebit", 32'($countones(wr_gray ^ exp_gray)), 1);
      exp_gray = tb_gray(10 + m);
      chk("wrap_gray",  32'(wr_gray), 32'(exp_gray));
      chk("wrap_level", 32'(wr_level), 32'(exp_lvl));
      chk("wrap_full",  32'(full), 0);
    end

    // Asynchronous reset in the middle of the burst.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_full",  32'(full), 0);
    chk("ar_afull", 32'(afull), 0);
    chk("ar_gray",  32'(wr_gray), 0);
    chk("ar_level", 32'(wr_level), 0);
    chk("ar_ovf",   32'(ovf), 0);
    chk("ar_sync0", 32'(u_dut.u_rd_sync.stage_q[0]), 0);
    chk("ar_sync1", 32'(u_dut.u_rd_sync.stage_q[1]), 0);
    wr_en = 1'b0; rd_gray = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gray",  32'(wr_gray), 0);
    chk("post_rst_level", 32'(wr_level), 0);
    chk("post_rst_full",  32'(full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
